// File: rtl/alu_seq_param_if.sv
// Operand/result handshake bundle for alu_seq_param.
// master = operand source / result sink side, slave = ALU side.
interface alu_seq_param_if #(
    parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             c;
  logic             z;
  logic             n;
  logic             v;
  logic             busy;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, y, c, z, n, v, busy
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, y, c, z, n, v, busy
  );
endinterface

// File: rtl/alu_seq_param.sv
// Registered WIDTH-bit ALU with valid/ready on both sides and Z/N/V/C flags.
// Define ALU_MUL_EN to build the iterative shift-add multiplier for op 8.
module alu_seq_param #(
    parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  alu_seq_param_if.slave bus
);
  localparam int M = WIDTH - 1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;

`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             c_q, c_d;
  logic             z_q, z_d;
  logic             n_q, n_d;
  logic             v_q, v_d;

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
`endif

  logic             in_ready;
  logic             accept;
  logic             is_mul;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] alu_y;
  logic             alu_c;
  logic             alu_v;

  assign in_ready = (state_q == IDLE) || (state_q == DONE && bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
`ifdef ALU_MUL_EN
  assign is_mul   = (bus.op == OP_MUL);
`else
  assign is_mul   = 1'b0;
`endif

  // Single-cycle datapath for every non-multiply opcode; reserved codes fall to default.
  always_comb begin
    sum   = {1'b0, bus.a} + {1'b0, bus.b};
    diff  = {1'b0, bus.a} - {1'b0, bus.b};
    alu_y = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (bus.op)
      OP_ADD: begin
        alu_y = sum[M:0];
        alu_c = sum[WIDTH];
        alu_v = (bus.a[M] == bus.b[M]) && (sum[M] != bus.a[M]);
      end
      OP_SUB: begin
        alu_y = diff[M:0];
        alu_c = diff[WIDTH];
        alu_v = (bus.a[M] != bus.b[M]) && (diff[M] != bus.a[M]);
      end
      OP_AND: alu_y = bus.a & bus.b;
      OP_OR:  alu_y = bus.a | bus.b;
      OP_XOR: alu_y = bus.a ^ bus.b;
      OP_NOT: alu_y = ~bus.a;
      OP_SHL: begin
        alu_y = {bus.a[M-1:0], 1'b0};
        alu_c = bus.a[M];
      end
      OP_SHR: begin
        alu_y = {1'b0, bus.a[M:1]};
        alu_c = bus.a[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    y_d      = y_q;
    c_d      = c_q;
    z_d      = z_q;
    n_d      = n_q;
    v_d      = v_q;
`ifdef ALU_MUL_EN
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
`endif
    if (accept) begin
      if (is_mul) begin
`ifdef ALU_MUL_EN
        state_d  = EXEC;
        acc_d    = '0;
        mcand_d  = {{WIDTH{1'b0}}, bus.a};
        mplier_d = bus.b;
        cnt_d    = '0;
`endif
      end else begin
        state_d = DONE;
        y_d     = alu_y;
        c_d     = alu_c;
        v_d     = alu_v;
        z_d     = (alu_y == '0);
        n_d     = alu_y[M];
      end
    end else if (state_q == DONE && bus.out_ready) begin
      state_d = IDLE;
    end
`ifdef ALU_MUL_EN
    // WIDTH add/shift steps, then one more cycle to publish the product.
    if (state_q == EXEC) begin
      if (cnt_q == CW'(WIDTH)) begin
        state_d = DONE;
        y_d     = acc_q[M:0];
        c_d     = |acc_q[2*WIDTH-1:WIDTH];
        v_d     = 1'b0;
        z_d     = (acc_q[M:0] == '0);
        n_d     = acc_q[M];
      end else begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      y_q      <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      v_q      <= 1'b0;
`ifdef ALU_MUL_EN
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      y_q      <= y_d;
      c_q      <= c_d;
      z_q      <= z_d;
      n_q      <= n_d;
      v_q      <= v_d;
`ifdef ALU_MUL_EN
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.y         = y_q;
  assign bus.c         = c_q;
  assign bus.z         = z_q;
  assign bus.n         = n_q;
  assign bus.v         = v_q;
endmodule
